// File: rtl/memory_interface.sv
// Core-to-bus memory bridge: accept -> bus_request next cycle, memory_valid >= 2 cycles after accept.
// Backpressure: memory_ready low while a transfer is in flight; request held until bus_grant.
module memory_interface (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_memory_enable,
  input  logic        i_memory_command,
  input  logic        i_access_word,
  input  logic [31:0] i_address,
  input  logic [31:0] i_write_data,
  input  logic [2:0]  i_load_type,
  input  logic [1:0]  i_store_type,
  output logic        o_memory_ready,
  output logic        o_memory_valid,
  output logic [31:0] o_read_data,
  output logic        o_misaligned_exception,
  output logic        o_bus_request,
  output logic        o_bus_write,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_write_data,
  output logic [3:0]  o_bus_byte_enable,
  input  logic        i_bus_grant,
  input  logic        i_bus_response_valid,
  input  logic [31:0] i_bus_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_next_state;
  logic        w_accept, w_capture;
  logic        w_is_byte, w_is_half;
  logic [3:0]  w_byte_enable;
  logic [31:0] w_write_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  logic        r_bus_write;
  logic [31:0] r_bus_address;
  logic [31:0] r_bus_write_data;
  logic [3:0]  r_bus_byte_enable;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_load_type;
  logic [31:0] r_read_data;

  // Unrecognised load/store encodings fall through to word width.
  always_comb begin
    w_is_byte = 1'b0;
    w_is_half = 1'b0;
    if (i_memory_command) begin
      w_is_byte = (i_store_type == 2'b00);
      w_is_half = (i_store_type == 2'b01);
    end else if (!i_access_word) begin
      w_is_byte = (i_load_type[1:0] == 2'b00);
      w_is_half = (i_load_type[1:0] == 2'b01);
    end
  end

  assign o_misaligned_exception = w_is_half ? i_address[0] : (!w_is_byte && (|i_address[1:0]));

  always_comb begin
    w_byte_enable = 4'b1111;
    w_write_data  = i_write_data;
    if (i_memory_command && w_is_byte) begin
      w_byte_enable = 4'b0001 << i_address[1:0];
      w_write_data  = {4{i_write_data[7:0]}};
    end else if (i_memory_command && w_is_half) begin
      w_byte_enable = 4'b0011 << i_address[1:0];
      w_write_data  = {2{i_write_data[15:0]}};
    end
  end

  always_comb begin
    case (r_addr_lo)
      2'd0:    w_byte = i_bus_read_data[7:0];
      2'd1:    w_byte = i_bus_read_data[15:8];
      2'd2:    w_byte = i_bus_read_data[23:16];
      default: w_byte = i_bus_read_data[31:24];
    endcase
    w_half = r_addr_lo[1] ? i_bus_read_data[31:16] : i_bus_read_data[15:0];
    case (r_load_type)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = i_bus_read_data;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_memory_enable && !o_misaligned_exception) begin
          w_accept     = 1'b1;
          w_next_state = S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (i_bus_grant && i_bus_response_valid) begin
          w_capture    = 1'b1;
          w_next_state = S_DONE;
        end else if (i_bus_grant) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_bus_response_valid) begin
          w_capture    = 1'b1;
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state           <= S_IDLE;
      r_bus_write       <= 1'b0;
      r_bus_address     <= 32'd0;
      r_bus_write_data  <= 32'd0;
      r_bus_byte_enable <= 4'd0;
      r_addr_lo         <= 2'd0;
      r_load_type       <= 3'd0;
      r_read_data       <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_bus_write       <= i_memory_command;
        r_bus_address     <= {i_address[31:2], 2'b00};
        r_bus_write_data  <= w_write_data;
        r_bus_byte_enable <= w_byte_enable;
        r_addr_lo         <= i_address[1:0];
        r_load_type       <= i_access_word ? 3'b010 : i_load_type;
      end
      // Write acks carry no data, so read_data keeps the last load result.
      if (w_capture && !r_bus_write)
        r_read_data <= w_load_data;
    end
  end

  assign o_memory_ready    = (r_state == S_IDLE);
  assign o_memory_valid    = (r_state == S_DONE);
  assign o_read_data       = r_read_data;
  assign o_bus_request     = (r_state == S_REQUEST);
  assign o_bus_write       = r_bus_write;
  assign o_bus_address     = r_bus_address;
  assign o_bus_write_data  = r_bus_write_data;
  assign o_bus_byte_enable = r_bus_byte_enable;

endmodule

// File: tb/tb_memory_interface.sv
// Randomized and directed bench for memory_interface against a width/offset arithmetic model.
module tb_memory_interface;

  logic        clk = 1'b0;
  logic        reset, en, cmd, aw;
  logic [31:0] addr, wd;
  logic [2:0]  lt;
  logic [1:0]  st;
  logic        ready, valid, mis, breq, bwr, grant, resp;
  logic [31:0] rdata, baddr, bwdata, brdata;
  logic [3:0]  bbe;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] rd_model;

  always #5 clk = ~clk;

  memory_interface dut (
    .i_clk(clk), .i_reset(reset), .i_memory_enable(en), .i_memory_command(cmd),
    .i_access_word(aw), .i_address(addr), .i_write_data(wd), .i_load_type(lt),
    .i_store_type(st), .o_memory_ready(ready), .o_memory_valid(valid),
    .o_read_data(rdata), .o_misaligned_exception(mis), .o_bus_request(breq),
    .o_bus_write(bwr), .o_bus_address(baddr), .o_bus_write_data(bwdata),
    .o_bus_byte_enable(bbe), .i_bus_grant(grant), .i_bus_response_valid(resp),
    .i_bus_read_data(brdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Full transaction: g cycles before grant, r cycles after grant until response.
  task automatic access(input bit c, input bit a, input logic [31:0] ad, input logic [31:0] w,
                        input logic [2:0] l, input logic [1:0] s, input int g, input int r,
                        input logic [31:0] raw);
    int          size, off;
    bit          sgn, exp_mis;
    logic [31:0] tmp, exp_wd, mask, v;
    logic [3:0]  exp_be;
    off = int'(ad % 4);
    if (c)      size = (s == 0) ? 1 : (s == 1) ? 2 : 4;
    else if (a) size = 4;
    else        size = (l == 0 || l == 4) ? 1 : (l == 1 || l == 5) ? 2 : 4;
    sgn     = !c && !a && (l == 0 || l == 1);
    exp_mis = (ad % size) != 0;
    tmp     = ((32'd1 << size) - 32'd1) << off;
    exp_be  = c ? tmp[3:0] : 4'hF;
    exp_wd  = (size == 1) ? 32'(w[7:0]) * 32'h01010101 :
              (size == 2) ? 32'(w[15:0]) * 32'h00010001 : w;
    mask    = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
    v       = (raw >> (8 * off)) & mask;
    if (sgn && v[8 * size - 1]) v = v | ~mask;

    en = 1'b1; cmd = c; aw = a; addr = ad; wd = w; lt = l; st = s;
    #1;
    chk("misaligned", {31'd0, mis}, {31'd0, exp_mis});
    chk("ready_idle", {31'd0, ready}, 32'd1);
    @(negedge clk);
    en = 1'b0;
    if (exp_mis) begin
      chk("mis_no_req", {31'd0, breq}, 32'd0);
      chk("mis_ready", {31'd0, ready}, 32'd1);
      return;
    end
    chk("req_hi", {31'd0, breq}, 32'd1);
    chk("ready_busy", {31'd0, ready}, 32'd0);
    chk("bus_addr", baddr, {ad[31:2], 2'b00});
    chk("bus_be", {28'd0, bbe}, {28'd0, exp_be});
    chk("bus_write", {31'd0, bwr}, {31'd0, c});
    if (c) chk("bus_wdata", bwdata, exp_wd);
    for (int k = 0; k < g; k++) begin
      grant = 1'b0; resp = 1'($urandom_range(0, 1)); brdata = $urandom;
      @(negedge clk);
      resp = 1'b0;
      chk("req_hold", {31'd0, breq}, 32'd1);
      chk("bus_addr_hold", baddr, {ad[31:2], 2'b00});
      chk("nv_req", {31'd0, valid}, 32'd0);
    end
    grant = 1'b1; resp = (r == 0); brdata = (r == 0) ? raw : $urandom;
    @(negedge clk);
    grant = 1'b0; resp = 1'b0;
    if (r > 0) chk("req_lo_wait", {31'd0, breq}, 32'd0);
    for (int k = 0; k < r; k++) begin
      chk("nv_wait", {31'd0, valid}, 32'd0);
      resp = (k == r - 1); brdata = (k == r - 1) ? raw : $urandom;
      @(negedge clk);
      resp = 1'b0;
    end
    chk("valid_done", {31'd0, valid}, 32'd1);
    if (!c) rd_model = v;
    chk("read_data", rdata, rd_model);
    @(negedge clk);
    chk("valid_pulse", {31'd0, valid}, 32'd0);
    chk("ready_back", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b0; cmd = 1'b0; aw = 1'b0; addr = 32'd0; wd = 32'd0;
    lt = 3'd0; st = 2'd0; grant = 1'b0; resp = 1'b0; brdata = 32'd0; rd_model = 32'd0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_req", {31'd0, breq}, 32'd0);
    chk("rst_bwr", {31'd0, bwr}, 32'd0);
    chk("rst_baddr", baddr, 32'd0);
    chk("rst_bwdata", bwdata, 32'd0);
    chk("rst_be", {28'd0, bbe}, 32'd0);

    access(0, 1, 32'h100, 0, 3'b000, 2'b00, 2, 1, 32'hDEADBEEF);
    access(0, 0, 32'h203, 0, 3'b000, 2'b00, 0, 1, 32'h80F17F22);
    access(0, 0, 32'h203, 0, 3'b100, 2'b00, 1, 0, 32'h80F17F22);
    access(0, 0, 32'h202, 0, 3'b001, 2'b00, 0, 0, 32'h80F17F22);
    access(0, 0, 32'h200, 0, 3'b101, 2'b00, 1, 2, 32'h80F17F22);
    access(1, 0, 32'h301, 32'h12345678, 3'b000, 2'b00, 1, 1, 32'hCAFEF00D);
    access(1, 0, 32'h302, 32'h12345678, 3'b000, 2'b01, 0, 0, 32'hCAFEF00D);
    access(0, 0, 32'h102, 0, 3'b010, 2'b00, 0, 0, 0);
    access(0, 0, 32'h101, 0, 3'b001, 2'b00, 0, 0, 0);
    access(1, 0, 32'h103, 32'h1, 3'b000, 2'b10, 0, 0, 0);
    access(0, 0, 32'h101, 0, 3'b000, 2'b00, 0, 0, 32'h0000AB00);

    resp = 1'b1; brdata = 32'h55555555;
    @(negedge clk);
    resp = 1'b0;
    chk("stray_nv", {31'd0, valid}, 32'd0);
    chk("stray_ready", {31'd0, ready}, 32'd1);

    en = 1'b1; cmd = 1'b0; aw = 1'b1; addr = 32'h404;
    @(negedge clk);
    en = 1'b0; grant = 1'b1;
    @(negedge clk);
    grant = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; rd_model = 32'd0;
    chk("mrst_ready", {31'd0, ready}, 32'd1);
    chk("mrst_valid", {31'd0, valid}, 32'd0);
    chk("mrst_rdata", rdata, 32'd0);
    chk("mrst_req", {31'd0, breq}, 32'd0);
    chk("mrst_baddr", baddr, 32'd0);
    chk("mrst_be", {28'd0, bbe}, 32'd0);
    resp = 1'b1; brdata = 32'h77777777;
    @(negedge clk);
    resp = 1'b0;
    chk("late_resp_nv", {31'd0, valid}, 32'd0);
    @(negedge clk);
    chk("late_resp_nv2", {31'd0, valid}, 32'd0);
    access(0, 0, 32'h408, 0, 3'b010, 2'b00, 1, 1, 32'h13579BDF);

    for (int i = 0; i < 80; i++) begin
      logic rc, ra;
      rc = 1'($urandom_range(0, 1));
      ra = !rc && ($urandom_range(0, 3) == 0);
      access(rc, ra, $urandom, $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
